// File: rtl/onehot_opcode_encoder_pkg.sv
// Shared constants, opcode values and FSM encoding for the one-hot opcode encoder.
package onehot_opcode_encoder_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned N_LINES  = 1 << OPCODE_W;

  localparam logic [OPCODE_W-1:0] OP0 = 3'd0;
  localparam logic [OPCODE_W-1:0] OP1 = 3'd1;
  localparam logic [OPCODE_W-1:0] OP2 = 3'd2;
  localparam logic [OPCODE_W-1:0] OP3 = 3'd3;
  localparam logic [OPCODE_W-1:0] OP4 = 3'd4;
  localparam logic [OPCODE_W-1:0] OP5 = 3'd5;
  localparam logic [OPCODE_W-1:0] OP6 = 3'd6;
  localparam logic [OPCODE_W-1:0] OP7 = 3'd7;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational MSB-priority encoder with any-set and more-than-one-set flags.
module onehot_prio_enc #(
  parameter  int unsigned OPCODE_W = 3,
  localparam int unsigned N        = 1 << OPCODE_W
) (
  input  logic [N-1:0]        lines,
  output logic [OPCODE_W-1:0] index,
  output logic                any_set,
  output logic                multi_set
);

  localparam int unsigned CntW = OPCODE_W + 1;

  logic [CntW-1:0] popcnt;

  // Ascending scan: the last set bit seen wins, giving MSB priority.
  always_comb begin
    index  = '0;
    popcnt = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (lines[k]) begin
        index  = k[OPCODE_W-1:0];
        popcnt = popcnt + CntW'(1);
      end
    end
  end

  assign any_set   = (popcnt != '0);
  assign multi_set = (popcnt > CntW'(1));

endmodule

// File: rtl/onehot_opcode_encoder.sv
// Registered one-hot to binary opcode encoder with valid/ready handshake,
// malformed-input flags and a saturating error counter.
module onehot_opcode_encoder #(
  parameter int unsigned OPCODE_W = onehot_opcode_encoder_pkg::OPCODE_W,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [(1<<OPCODE_W)-1:0]   instruction,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OPCODE_W-1:0]        opcode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       zero_hot,
  output logic                       multi_hot,
  output logic [ERRCNT_W-1:0]        err_count,
  input  logic                       clr_err
);

  import onehot_opcode_encoder_pkg::*;

  localparam int unsigned N = 1 << OPCODE_W;
  localparam logic [ERRCNT_W-1:0] ErrMax = {ERRCNT_W{1'b1}};

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic                  zero_hot_q, zero_hot_d;
  logic                  multi_hot_q, multi_hot_d;
  logic [ERRCNT_W-1:0]   err_count_q, err_count_d;

  logic                  accept;
  logic [N-1:0]          masked;
  logic [OPCODE_W-1:0]   enc_index;
  logic                  any_set;
  logic                  multi_set;

  assign in_ready = (state_q == StEmpty) | out_ready;
  assign accept   = in_valid & in_ready;
  // Gate the bus so X on idle lines never reaches the encoder.
  assign masked   = instruction & {N{in_valid}};

  onehot_prio_enc #(
    .OPCODE_W (OPCODE_W)
  ) u_prio_enc (
    .lines     (masked),
    .index     (enc_index),
    .any_set   (any_set),
    .multi_set (multi_set)
  );

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    zero_hot_d  = zero_hot_q;
    multi_hot_d = multi_hot_q;
    // Clear first so a same-cycle errored accept still counts once.
    err_count_d = clr_err ? '0 : err_count_q;

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (out_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      opcode_d    = enc_index;
      zero_hot_d  = !any_set;
      multi_hot_d = multi_set;
      if ((!any_set || multi_set) && (err_count_d != ErrMax)) begin
        err_count_d = err_count_d + ERRCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      opcode_q    <= OP0[OPCODE_W-1:0];
      zero_hot_q  <= 1'b0;
      multi_hot_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      zero_hot_q  <= zero_hot_d;
      multi_hot_q <= multi_hot_d;
      err_count_q <= err_count_d;
    end
  end

  assign opcode    = opcode_q;
  assign out_valid = (state_q == StFull);
  assign zero_hot  = zero_hot_q;
  assign multi_hot = multi_hot_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_opcode_encoder.sv
// Randomised self-checking bench for onehot_opcode_encoder against a
// transaction-level reference model.
module tb_onehot_opcode_encoder;

  localparam int unsigned OW = 3;
  localparam int unsigned NL = 8;
  localparam int unsigned EW = 2;
  localparam int          ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [NL-1:0] instruction;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] opcode;
  logic          out_valid;
  logic          out_ready;
  logic          zero_hot;
  logic          multi_hot;
  logic [EW-1:0] err_count;
  logic          clr_err;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the single output slot.
  bit m_valid = 1'b0;
  int m_op    = 0;
  bit m_zh    = 1'b0;
  bit m_mh    = 1'b0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  onehot_opcode_encoder #(
    .OPCODE_W (OW),
    .ERRCNT_W (EW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .zero_hot    (zero_hot),
    .multi_hot   (multi_hot),
    .err_count   (err_count),
    .clr_err     (clr_err)
  );

  function automatic int hi_index(input int v);
    int k = 0;
    while (v > 1) begin
      v = v >> 1;
      k++;
    end
    return k;
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic cycle();
    int pc;
    bit acc;
    if (reset) begin
      m_valid = 0; m_op = 0; m_zh = 0; m_mh = 0; m_cnt = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (clr_err) m_cnt = 0;
      if (acc) begin
        pc   = $countones(instruction);
        m_zh = (pc == 0);
        m_mh = (pc > 1);
        m_op = (pc == 0) ? 0 : hi_index(int'(instruction));
        if ((m_zh || m_mh) && m_cnt < ERR_MAX) m_cnt++;
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 0; clr_err = 0; instruction = '0;
    cycle(); cycle();
    reset = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d want 0", opcode); end
    checks++;
    if ({zero_hot, multi_hot} !== 2'b00) begin
      errors++; $display("FAIL reset_flags got %b%b want 00", zero_hot, multi_hot);
    end
    checks++;
    if (err_count !== 2'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_onehot_sweep();
    logic [NL-1:0] dec;
    in_valid = 1; out_ready = 1;
    for (int k = 7; k >= 0; k--) begin
      instruction = NL'(1) << k;
      cycle();
      checks++;
      if (out_valid !== 1'b1 || opcode !== 3'(k) || opcode !== 3'(m_op)) begin
        errors++; $display("FAIL sweep_opcode got v=%b op=%0d want v=1 op=%0d", out_valid, opcode, k);
      end
      dec = NL'(1) << opcode;
      checks++;
      if (dec !== instruction) begin
        errors++; $display("FAIL sweep_roundtrip got %b want %b", dec, instruction);
      end
      checks++;
      if ({zero_hot, multi_hot} !== 2'b00) begin
        errors++; $display("FAIL sweep_flags got %b%b want 00", zero_hot, multi_hot);
      end
    end
    in_valid = 0; instruction = 'x;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || err_count !== 2'd0) begin
      errors++; $display("FAIL sweep_drain got v=%b cnt=%0d want v=0 cnt=0", out_valid, err_count);
    end
  endtask

  task automatic test_malformed();
    in_valid = 1; out_ready = 1; instruction = 8'b00000000;
    cycle();
    checks++;
    if (opcode !== 3'd0 || zero_hot !== 1'b1 || multi_hot !== 1'b0) begin
      errors++; $display("FAIL zero_hot got op=%0d zh=%b mh=%b want op=0 zh=1 mh=0", opcode, zero_hot, multi_hot);
    end
    instruction = 8'b01001001;
    cycle();
    checks++;
    if (opcode !== 3'd6 || zero_hot !== 1'b0 || multi_hot !== 1'b1) begin
      errors++; $display("FAIL multi_hot got op=%0d zh=%b mh=%b want op=6 zh=0 mh=1", opcode, zero_hot, multi_hot);
    end
    in_valid = 0; instruction = '0;
    cycle();
    checks++;
    if (err_count !== 2'd2 || err_count !== 2'(m_cnt)) begin
      errors++; $display("FAIL malformed_count got %0d want 2", err_count);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1; out_ready = 1; instruction = 8'b00001000;
    cycle();
    out_ready = 0; instruction = 8'b00000010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || opcode !== 3'd3) begin
        errors++; $display("FAIL bp_hold got v=%b op=%0d want v=1 op=3", out_valid, opcode);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || opcode !== 3'd1) begin
      errors++; $display("FAIL bp_release got v=%b op=%0d want v=1 op=1", out_valid, opcode);
    end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_streaming();
    int q[$];
    int k;
    int want;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(7, 0);
      instruction = NL'(1) << k;
      q.push_back(k);
      cycle();
      want = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || opcode !== 3'(want)) begin
        errors++; $display("FAIL stream_%0d got v=%b op=%0d want v=1 op=%0d", i, out_valid, opcode, want);
      end
    end
    in_valid = 0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || err_count !== 2'(m_cnt)) begin
      errors++; $display("FAIL stream_drain got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, err_count, m_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [NL-1:0] r;
    reset = 1;
    cycle();
    reset = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        r = '0;
      end else begin
        do r = NL'($urandom_range(255, 0)); while ($countones(r) < 2);
      end
      instruction = r;
      cycle();
    end
    checks++;
    if (err_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", err_count); end
    clr_err = 1; instruction = 8'b11000000;
    cycle();
    checks++;
    if (err_count !== 2'd1 || opcode !== 3'd7 || multi_hot !== 1'b1) begin
      errors++; $display("FAIL clr_with_err got cnt=%0d op=%0d mh=%b want cnt=1 op=7 mh=1", err_count, opcode, multi_hot);
    end
    instruction = 8'b00000001;
    cycle();
    clr_err = 0;
    checks++;
    if (err_count !== 2'd0) begin errors++; $display("FAIL clr_clean got %0d want 0", err_count); end
    in_valid = 0;
    cycle();
  endtask

  task automatic test_random();
    logic [7:0] got;
    logic [7:0] exp;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      clr_err   = ($urandom_range(15, 0) == 0);
      case ($urandom_range(3, 0))
        0:       instruction = '0;
        1:       instruction = NL'($urandom_range(255, 0));
        default: instruction = NL'(1) << $urandom_range(7, 0);
      endcase
      if (!in_valid && $urandom_range(1, 0) == 1) instruction = 'x;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL rand_in_ready_%0d got %b want %b", i, in_ready, (!m_valid || out_ready));
      end
      cycle();
      got = {out_valid, opcode, zero_hot, multi_hot, err_count};
      exp = {m_valid, 3'(m_op), m_zh, m_mh, 2'(m_cnt)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rand_state_%0d got %b want %b", i, got, exp);
      end
    end
    clr_err = 0; in_valid = 0; out_ready = 1;
    cycle();
  endtask

  task automatic test_reset_midflight();
    in_valid = 1; out_ready = 1; instruction = '0;
    cycle();
    instruction = 8'b00100000;
    cycle();
    in_valid = 0; out_ready = 0;
    checks++;
    if (out_valid !== 1'b1 || opcode !== 3'd5 || err_count === 2'd0) begin
      errors++; $display("FAIL pre_reset got v=%b op=%0d cnt=%0d want v=1 op=5 cnt>0", out_valid, opcode, err_count);
    end
    reset = 1; in_valid = 1; clr_err = 0; instruction = 8'b10000000;
    cycle();
    reset = 0; in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || opcode !== 3'd0 || err_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b op=%0d cnt=%0d rdy=%b want v=0 op=0 cnt=0 rdy=1",
                         out_valid, opcode, err_count, in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL no_replay got v=%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_malformed();
    test_backpressure();
    test_streaming();
    test_saturation();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
